motor_pwm_driver: RTL and testbench

MOTOR_PWM_DRIVER -- requirements
Module: motor_pwm_driver

---
 rtl/motor_pwm_driver_if.sv | 22 ++
 rtl/motor_pwm_driver.sv | 86 ++++++++
 tb/tb_motor_pwm_driver.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/motor_pwm_driver_if.sv
// motor_pwm_driver_if: steering-stage command inputs and H-bridge outputs of the motor PWM driver
//   en, widthChassis, direction : commands into the driver (master drives)
//   dir_out, pwm_a, pwm_b       : H-bridge direction and enable pins (slave drives)
//   state, period_tick          : status outputs (slave drives)
interface motor_pwm_driver_if;
    logic        en;
    logic [15:0] widthChassis;
    logic [3:0]  direction;
    logic [3:0]  dir_out;
    logic        pwm_a;
    logic        pwm_b;
    logic [1:0]  state;
    logic        period_tick;
    modport master (
        output en, widthChassis, direction,
        input  dir_out, pwm_a, pwm_b, state, period_tick
    );
    modport slave (
        input  en, widthChassis, direction,
        output dir_out, pwm_a, pwm_b, state, period_tick
    );
endinterface

// File: rtl/motor_pwm_driver.sv
// motor_pwm_driver: ramped H-bridge PWM driver with dead-time coasting on direction reversal
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : command inputs (en, widthChassis, direction) and outputs
//           (dir_out, pwm_a, pwm_b, state, period_tick)
module motor_pwm_driver #(
    parameter logic [15:0] PERIOD      = 16'd50000,
    parameter logic [15:0] DEAD_CYCLES = 16'd5000,
    parameter logic [15:0] RAMP_STEP   = 16'd2000
) (
    input logic               clk,
    input logic               rst_n,
    motor_pwm_driver_if.slave bus
);
    localparam logic [1:0] STOP = 2'b00, RUN = 2'b01, DEAD = 2'b10;
    logic [15:0] cnt, applied, dead_cnt, target, ramp_next;
    logic [16:0] ramped;
    logic [3:0]  dir_out;
    logic [1:0]  state;
    logic        pwm, period_tick, wrap, stop_req;
    always_comb begin
        wrap      = cnt == PERIOD - 16'd1;
        stop_req  = !bus.en || bus.direction == 4'b0000 || bus.widthChassis == 16'd0;
        target    = ({1'b0, bus.widthChassis} > {1'b0, PERIOD}) ? PERIOD : bus.widthChassis;
        ramped    = {1'b0, applied} + {1'b0, RAMP_STEP};
        // ramp only upward; a lower request is applied immediately at the wrap
        ramp_next = (target > applied) ? ((ramped > {1'b0, target}) ? target : ramped[15:0]) : target;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            applied     <= '0;
            dead_cnt    <= '0;
            state       <= STOP;
            dir_out     <= '0;
            pwm         <= 1'b0;
            period_tick <= 1'b0;
        end else begin
            cnt         <= wrap ? 16'd0 : cnt + 16'd1;
            period_tick <= wrap;
            pwm         <= state == RUN && cnt < applied;
            case (state)
                STOP: begin
                    applied <= '0;
                    if (!stop_req) begin
                        state   <= RUN;
                        dir_out <= bus.direction;
                    end
                end
                RUN: begin
                    if (stop_req) begin
                        state   <= STOP;
                        dir_out <= '0;
                        applied <= '0;
                    end else if (bus.direction != dir_out) begin
                        // coast with the bridge open before driving the new polarity
                        state    <= DEAD;
                        dead_cnt <= DEAD_CYCLES - 16'd1;
                        dir_out  <= '0;
                        applied  <= '0;
                    end else if (wrap) begin
                        applied <= ramp_next;
                    end
                end
                DEAD: begin
                    if (dead_cnt == 16'd0) begin
                        state   <= stop_req ? STOP : RUN;
                        dir_out <= stop_req ? 4'b0000 : bus.direction;
                    end else begin
                        dead_cnt <= dead_cnt - 16'd1;
                    end
                end
                default: begin
                    state   <= STOP;
                    dir_out <= '0;
                    applied <= '0;
                end
            endcase
        end
    end
    assign bus.dir_out     = dir_out;
    assign bus.pwm_a       = pwm;
    assign bus.pwm_b       = pwm;
    assign bus.state       = state;
    assign bus.period_tick = period_tick;
endmodule

// File: tb/tb_motor_pwm_driver.sv
// tb_motor_pwm_driver: directed self-checking bench for motor_pwm_driver (PERIOD=100, DEAD_CYCLES=10, RAMP_STEP=20)
module tb_motor_pwm_driver;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    motor_pwm_driver_if bus();
    motor_pwm_driver #(.PERIOD(16'd100), .DEAD_CYCLES(16'd10), .RAMP_STEP(16'd20)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask
    // Advance to the cycle where period_tick is high; pwm highs seen on the way and cycles waited are checked.
    task automatic sync_tick(input string tag, input int exp_hi, input int exp_wait);
        int hi = 0;
        int n = 0;
        do begin
            @(negedge clk);
            n++;
            hi += int'(bus.pwm_a);
        end while (!bus.period_tick && n < 250);
        check({tag, "_tick_found"}, int'(bus.period_tick), 1);
        check({tag, "_pre_hi"}, hi, exp_hi);
        if (exp_wait >= 0) check({tag, "_wait"}, n, exp_wait);
    endtask
    // Count pwm highs over one full period starting after a tick cycle; ends on the next tick cycle.
    task automatic measure(input string tag, input int exp);
        int a = 0;
        int b = 0;
        int t = 0;
        repeat (100) begin
            @(negedge clk);
            a += int'(bus.pwm_a);
            b += int'(bus.pwm_b);
            t += int'(bus.period_tick);
        end
        check({tag, "_pwm_a"}, a, exp);
        check({tag, "_pwm_b"}, b, exp);
        check({tag, "_ticks"}, t, 1);
    endtask
    task automatic stop_case(input string tag);
        @(negedge clk);
        check({tag, "_state"}, int'(bus.state), 0);
        check({tag, "_dir"}, int'(bus.dir_out), 0);
        @(negedge clk);
        check({tag, "_pwm_low"}, int'(bus.pwm_a), 0);
    endtask
    initial begin
        bus.en = 1'b1;
        bus.direction = 4'b0110;
        bus.widthChassis = 16'd50;
        #2;
        check("rst_state", int'(bus.state), 0);
        check("rst_dir", int'(bus.dir_out), 0);
        check("rst_pwm_a", int'(bus.pwm_a), 0);
        check("rst_pwm_b", int'(bus.pwm_b), 0);
        check("rst_tick", int'(bus.period_tick), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ramp_dir", int'(bus.dir_out), 4'b0110);
        check("ramp_state", int'(bus.state), 1);
        sync_tick("ramp", 0, 99);
        measure("ramp1", 20);
        measure("ramp2", 40);
        measure("ramp3", 50);
        measure("ramp4", 50);
        repeat (60) @(negedge clk);
        bus.direction = 4'b1001;
        @(negedge clk);
        check("rev_state", int'(bus.state), 2);
        check("rev_dir", int'(bus.dir_out), 0);
        check("rev_pwm", int'(bus.pwm_a), 0);
        repeat (9) @(negedge clk);
        check("rev_dead_last", int'(bus.state), 2);
        check("rev_dead_dir", int'(bus.dir_out), 0);
        @(negedge clk);
        check("rev_run", int'(bus.state), 1);
        check("rev_newdir", int'(bus.dir_out), 4'b1001);
        sync_tick("rev", 0, -1);
        measure("rev1", 20);
        measure("rev2", 40);
        measure("rev3", 50);
        repeat (5) @(negedge clk);
        check("pre_stop_pwm", int'(bus.pwm_a), 1);
        bus.direction = 4'b0000;
        stop_case("stop_dir");
        bus.direction = 4'b1001;
        @(negedge clk);
        check("resume1", int'(bus.state), 1);
        bus.en = 1'b0;
        stop_case("stop_en");
        bus.en = 1'b1;
        @(negedge clk);
        check("resume2", int'(bus.dir_out), 4'b1001);
        bus.widthChassis = 16'd0;
        stop_case("stop_width");
        bus.widthChassis = 16'd65535;
        sync_tick("clamp", 0, -1);
        measure("clamp1", 20);
        measure("clamp2", 40);
        measure("clamp3", 60);
        measure("clamp4", 80);
        measure("clamp5", 100);
        measure("clamp6", 100);
        bus.widthChassis = 16'd80;
        measure("dec80a", 100);
        measure("dec80b", 80);
        bus.widthChassis = 16'd30;
        measure("dec30a", 80);
        measure("dec30b", 30);
        measure("dec30c", 30);
        bus.direction = 4'b0110;
        @(negedge clk);
        check("ar_dead", int'(bus.state), 2);
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("ar_state", int'(bus.state), 0);
        check("ar_dir", int'(bus.dir_out), 0);
        check("ar_pwm_a", int'(bus.pwm_a), 0);
        check("ar_pwm_b", int'(bus.pwm_b), 0);
        check("ar_tick", int'(bus.period_tick), 0);
        bus.widthChassis = 16'd40;
        @(negedge clk);
        @(negedge clk);
        check("ar_hold", int'(bus.state), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ar_run_dir", int'(bus.dir_out), 4'b0110);
        check("ar_run_state", int'(bus.state), 1);
        sync_tick("ar", 0, 99);
        measure("ar1", 20);
        measure("ar2", 40);
        measure("ar3", 40);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
